interval_timer_dev: RTL and testbench



---
 rtl/intdev_pkg.sv | 16 +
 rtl/inta_chain_link.sv | 26 ++
 rtl/interval_timer_dev.sv | 98 +++++++++
 tb/tb_interval_timer_dev.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/intdev_pkg.sv
// Shared definitions for interrupt-raising devices on the INTA daisy chain.
// Holds the vector bus width, the per-device vector constants and the
// two-state request enum used by every device's request state machine.
package intdev_pkg;

  localparam int INT_DATA_W = 32;

  localparam logic [INT_DATA_W-1:0] TIMER_VECTOR    = 32'h1;
  localparam logic [INT_DATA_W-1:0] KEYBOARD_VECTOR = 32'h2;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } req_state_e;

endpackage

// File: rtl/inta_chain_link.sv
// One link of the INTA daisy chain. A device with a pending request absorbs
// the acknowledge and drives its vector; otherwise the acknowledge passes on
// and the vector bus is released. Purely combinational.
// Ports:
//   INTA_IN  - acknowledge from upstream
//   pending  - this device has an outstanding request
//   INTA_OUT - acknowledge forwarded downstream
//   own      - this device owns the current acknowledge
//   DATA     - vector bus, Z unless owned
module inta_chain_link
  import intdev_pkg::*;
#(
  parameter logic [INT_DATA_W-1:0] VECTOR = TIMER_VECTOR
) (
  input  logic                  INTA_IN,
  input  logic                  pending,
  output logic                  INTA_OUT,
  output logic                  own,
  output logic [INT_DATA_W-1:0] DATA
);

  assign own      = INTA_IN & pending;
  assign INTA_OUT = INTA_IN & ~pending;
  assign DATA     = own ? VECTOR : {INT_DATA_W{1'bz}};

endmodule

// File: rtl/interval_timer_dev.sv
// Programmable interval timer raising a level interrupt; head of the INTA
// daisy chain. Counts enabled CLK cycles, requests on expiry, and drives
// VECTOR on DATA when it owns the acknowledge.
// Optional build macro: TIMER_OVERRUN_EN adds OVERRUN, a saturating count of
// expiries that landed while a request was still unserviced.
// Ports:
//   CLK, RST_N            - clock (posedge), async active-low reset
//   INTA_IN / INTA_OUT    - daisy-chain acknowledge in / forwarded out
//   INT                   - registered interrupt request
//   DATA                  - vector bus, Z when not owning
//   LD_PERIOD, PERIOD_IN  - load new period (0 treated as 1)
//   EN                    - count enable
//   OVERRUN               - (TIMER_OVERRUN_EN only) missed-expiry count
module interval_timer_dev
  import intdev_pkg::*;
#(
  parameter int                    CNT_W          = 32,
  parameter int unsigned           DEFAULT_PERIOD = 32'd1000,
  parameter logic [INT_DATA_W-1:0] VECTOR         = TIMER_VECTOR
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  INTA_IN,
  output logic                  INTA_OUT,
  output logic                  INT,
  output logic [INT_DATA_W-1:0] DATA,
  input  logic                  LD_PERIOD,
  input  logic [CNT_W-1:0]      PERIOD_IN,
  input  logic                  EN
`ifdef TIMER_OVERRUN_EN
  ,
  output logic [7:0]            OVERRUN
`endif
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] period, count, ld_val;
  logic             expire, own, pending;
  req_state_e       state;

  // A zero period would never reach the count==1 reload point; clamp to 1.
  assign ld_val = (PERIOD_IN == '0) ? ONE : PERIOD_IN;

  // Loading wins over the decrement, so a load on the count==1 edge
  // suppresses that expiry.
  assign expire = EN & ~LD_PERIOD & (count == ONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period <= DEF_P;
      count  <= DEF_P;
    end else if (LD_PERIOD) begin
      period <= ld_val;
      count  <= ld_val;
    end else if (EN) begin
      count <= (count == ONE) ? period : count - ONE;
    end
  end

  // Expiry outranks ack: a request arriving as the previous one is
  // acknowledged must not be lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (expire) state <= PEND;
        PEND:    if (own && !expire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pending = (state == PEND);
  assign INT     = pending;

  inta_chain_link #(.VECTOR(VECTOR)) u_link (
    .INTA_IN  (INTA_IN),
    .pending  (pending),
    .INTA_OUT (INTA_OUT),
    .own      (own),
    .DATA     (DATA)
  );

`ifdef TIMER_OVERRUN_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      OVERRUN <= 8'h00;
    else if (own)
      OVERRUN <= 8'h00;
    else if (expire && pending && OVERRUN != 8'hFF)
      OVERRUN <= OVERRUN + 8'h01;
  end
`endif

endmodule

// File: tb/tb_interval_timer_dev.sv
// Randomized scoreboard bench for interval_timer_dev. A reference model
// counts enabled cycles since the last load and expires whenever that count
// is a multiple of the period; per-cycle expected outputs are queued and a
// monitor compares them against the DUT.
module tb_interval_timer_dev;

  localparam logic [31:0] TV   = 32'h1;
  localparam int          DEFP = 4;

  logic        CLK = 1'b0;
  logic        RST_N, INTA_IN, LD_PERIOD, EN;
  logic [31:0] PERIOD_IN;
  wire         INTA_OUT, INT;
  wire  [31:0] DATA;
`ifdef TIMER_OVERRUN_EN
  wire  [7:0]  OVERRUN;
`endif

  interval_timer_dev #(.CNT_W(32), .DEFAULT_PERIOD(DEFP), .VECTOR(TV)) dut (
    .CLK(CLK), .RST_N(RST_N), .INTA_IN(INTA_IN), .INTA_OUT(INTA_OUT),
    .INT(INT), .DATA(DATA), .LD_PERIOD(LD_PERIOD), .PERIOD_IN(PERIOD_IN),
    .EN(EN)
`ifdef TIMER_OVERRUN_EN
    , .OVERRUN(OVERRUN)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       int_e;
    logic       inta_out_e;
    logic       own_e;
    logic [7:0] ovr_e;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0, total = 0, ncyc = 0;

  // reference model state
  int   m_period, m_phase, m_ovr;
  bit   m_pend;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_data(string nm, bit own_e);
    total++;
    if (own_e ? (DATA === TV) : (DATA !== TV)) passed++;
    else $display("FAIL %s: got %h want %s (t=%0t)", nm, DATA,
                  own_e ? "vector" : "released", $time);
  endtask

  task automatic model_reset();
    m_period = DEFP; m_phase = 0; m_pend = 0; m_ovr = 0;
  endtask

  // One cycle: drive inputs, queue what the DUT must show before the edge,
  // then advance the model through the edge.
  task automatic cyc(bit en, bit ld, int pin, bit inta);
    exp_t e;
    bit   own, expire;
    @(negedge CLK);
    EN = en; LD_PERIOD = ld; PERIOD_IN = pin; INTA_IN = inta;
    own          = inta && m_pend;
    e.int_e      = m_pend;
    e.inta_out_e = inta && !m_pend;
    e.own_e      = own;
    e.ovr_e      = 8'(m_ovr);
    e.cyc        = ncyc++;
    sb.push_back(e);
    expire = 0;
    if (ld) begin
      m_period = (pin == 0) ? 1 : pin;
      m_phase  = 0;
    end else if (en) begin
      m_phase++;
      expire = (m_phase % m_period) == 0;
    end
    if (own) m_ovr = 0;
    else if (expire && m_pend && m_ovr < 255) m_ovr++;
    if (expire) m_pend = 1;
    else if (own) m_pend = 0;
  endtask

  // monitor: DUT outputs are valid every cycle; sample mid low phase
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("INT c%0d", e.cyc), INT, e.int_e);
      chk($sformatf("INTA_OUT c%0d", e.cyc), INTA_OUT, e.inta_out_e);
      chk_data($sformatf("DATA c%0d", e.cyc), e.own_e);
`ifdef TIMER_OVERRUN_EN
      chk($sformatf("OVERRUN c%0d", e.cyc), OVERRUN, e.ovr_e);
`endif
    end
  end

  initial begin
    RST_N = 1'b0; INTA_IN = 1'b1; LD_PERIOD = 1'b0; EN = 1'b0; PERIOD_IN = '0;
    model_reset();
    #3;
    chk("reset INT", INT, 1'b0);
    chk("reset INTA_OUT", INTA_OUT, 1'b1);
    chk_data("reset DATA", 1'b0);
    @(negedge CLK);
    INTA_IN = 1'b0;
    RST_N   = 1'b1;

    // default period 4: INT rises after the 4th enabled edge
    repeat (5) cyc(1, 0, 0, 0);
    // single-cycle ack, then released
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // ack with nothing pending passes through
    cyc(0, 0, 0, 1);
    // zero period: expires every enabled cycle; ack at expiry keeps INT
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // load landing on the count==1 edge suppresses that expiry
    cyc(0, 1, 3, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 1, 5, 0);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    // overrun scenario: period 2, ten unacked enabled cycles, then ack
    cyc(0, 1, 2, 1);
    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // randomized traffic
    repeat (400)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 6), $urandom_range(0, 3) == 0);

    // reset during an acknowledge: outputs drop without a clock edge
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("midreset INT", INT, 1'b0);
    chk("midreset INTA_OUT", INTA_OUT, 1'b1);
    chk_data("midreset DATA", 1'b0);
`ifdef TIMER_OVERRUN_EN
    chk("midreset OVERRUN", OVERRUN, 8'h00);
`endif

    // bounded drain of the scoreboard
    repeat (3) @(negedge CLK);
    #4;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d left want 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
